// File: rtl/rtype_alu_pipe.sv
// rtype_alu_pipe: registered RV32/RV64 R-type execute unit with valid/ready
// handshakes on both sides. Defining RTYPE_MEXT_EN adds the M-extension:
// single-cycle multiply and an iterative restoring divider (IDLE/DIV/DONE).
module rtype_alu_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_result_q, out_result_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_illegal_q, out_illegal_d;

    logic               accept;
    logic               start_div;
    logic [XLEN-1:0]    fast_res;
    logic               fast_ill;
    logic [SHW-1:0]     shamt;

`ifdef RTYPE_MEXT_EN
    logic [2*XLEN-1:0]  mul_a, mul_b, prod;
    logic               div_zero, div_ovf, div_sgn;
    logic [XLEN-1:0]    abs1, abs2, div_res;
    logic [XLEN:0]      rem_sh, rem_sub;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    dvs_q, dvs_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               rem_sel_q, rem_sel_d;
    logic [TAG_W-1:0]   div_tag_q, div_tag_d;

    assign div_sgn = !funct3[0];
    assign abs1    = (div_sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    assign abs2    = (div_sgn && rs2[XLEN-1]) ? -rs2 : rs2;
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign div_res = rem_sel_q ? (neg_r_q ? -rem_q : rem_q)
                               : (neg_q_q ? -quo_q : quo_q);
    assign busy    = (state_q == DIV);
`else
    assign busy    = 1'b0;
`endif

    assign shamt       = rs2[SHW-1:0];
    assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

    // Decode and single-cycle execute; flags divides that need the iterative path
    always_comb begin
        fast_res  = '0;
        fast_ill  = 1'b0;
        start_div = 1'b0;
`ifdef RTYPE_MEXT_EN
        mul_a    = (funct3 == 3'b001 || funct3 == 3'b010) ? {{XLEN{rs1[XLEN-1]}}, rs1}
                                                         : {{XLEN{1'b0}}, rs1};
        mul_b    = (funct3 == 3'b001) ? {{XLEN{rs2[XLEN-1]}}, rs2} : {{XLEN{1'b0}}, rs2};
        prod     = mul_a * mul_b;
        div_zero = (rs2 == '0);
        div_ovf  = div_sgn && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
`endif
        case (funct7)
            7'b0000000: begin
                case (funct3)
                    3'b000: fast_res = rs1 + rs2;
                    3'b001: fast_res = rs1 << shamt;
                    3'b010: fast_res = XLEN'($signed(rs1) < $signed(rs2));
                    3'b011: fast_res = XLEN'(rs1 < rs2);
                    3'b100: fast_res = rs1 ^ rs2;
                    3'b101: fast_res = rs1 >> shamt;
                    3'b110: fast_res = rs1 | rs2;
                    3'b111: fast_res = rs1 & rs2;
                endcase
            end
            7'b0100000: begin
                case (funct3)
                    3'b000:  fast_res = rs1 - rs2;
                    3'b101:  fast_res = XLEN'($signed(rs1) >>> shamt);
                    default: fast_ill = 1'b1;
                endcase
            end
`ifdef RTYPE_MEXT_EN
            7'b0000001: begin
                case (funct3)
                    3'b000:                 fast_res = prod[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: fast_res = prod[2*XLEN-1:XLEN];
                    default: begin
                        if (div_zero)     fast_res = funct3[1] ? rs1 : '1;
                        else if (div_ovf) fast_res = funct3[1] ? '0 : rs1;
                        else              start_div = 1'b1;
                    end
                endcase
            end
`endif
            default: fast_ill = 1'b1;
        endcase
    end

    // Next state, output register load and divider stepping
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;
`ifdef RTYPE_MEXT_EN
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        rem_sel_d = rem_sel_q;
        div_tag_d = div_tag_q;
`endif
        if (accept && !start_div) begin
            out_valid_d   = 1'b1;
            out_result_d  = fast_res;
            out_tag_d     = in_tag;
            out_illegal_d = fast_ill;
        end
        case (state_q)
            IDLE: begin
`ifdef RTYPE_MEXT_EN
                // Magnitudes are captured at accept so DIV spends exactly XLEN steps
                if (accept && start_div) begin
                    state_d   = DIV;
                    quo_d     = abs1;
                    rem_d     = '0;
                    dvs_d     = abs2;
                    cnt_d     = '0;
                    neg_q_d   = div_sgn && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                    neg_r_d   = div_sgn && rs1[XLEN-1];
                    rem_sel_d = funct3[1];
                    div_tag_d = in_tag;
                end
`endif
            end
`ifdef RTYPE_MEXT_EN
            DIV: begin
                if (!rem_sub[XLEN]) begin
                    rem_d = rem_sub[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN - 1)) state_d = DONE;
            end
            DONE: begin
                out_valid_d   = 1'b1;
                out_result_d  = div_res;
                out_tag_d     = div_tag_q;
                out_illegal_d = 1'b0;
                state_d       = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
        end
    end

`ifdef RTYPE_MEXT_EN
    // Divider working registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            div_tag_q <= '0;
        end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            rem_sel_q <= rem_sel_d;
            div_tag_q <= div_tag_d;
        end
    end
`endif

endmodule

// File: tb/tb_rtype_alu_pipe.sv
// tb_rtype_alu_pipe: directed and randomized bench for rtype_alu_pipe (XLEN=32)
// with an arithmetic reference model and an in-order result scoreboard.
module tb_rtype_alu_pipe;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk, reset;
    logic             in_valid, in_ready;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [XLEN-1:0]  rs1, rs2, out_result;
    logic             out_valid, out_ready, out_illegal, busy;

    logic             hold_ready, rand_ready;
    int               n_checks, n_fail;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;
    exp_t exp_q[$];

    logic        prev_stall;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    logic        prev_ill;

    rtype_alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct7(funct7), .funct3(funct3), .in_tag(in_tag),
        .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_illegal(out_illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer readiness changes just after each rising edge
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : hold_ready;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: returns {illegal, result}
    function automatic logic [32:0] model(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        longint             sp;
        logic [63:0]        up;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sp  = 0;
        up  = 0;
        case ({f7, f3})
            10'b0000000_000: return {1'b0, 32'(a + b)};
            10'b0100000_000: return {1'b0, 32'(a - b)};
            10'b0000000_001: return {1'b0, 32'(a << b[4:0])};
            10'b0000000_010: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
            10'b0000000_011: return {1'b0, (a < b) ? 32'd1 : 32'd0};
            10'b0000000_100: return {1'b0, a ^ b};
            10'b0000000_101: return {1'b0, 32'(a >> b[4:0])};
            10'b0100000_101: return {1'b0, 32'(sa >>> b[4:0])};
            10'b0000000_110: return {1'b0, a | b};
            10'b0000000_111: return {1'b0, a & b};
`ifdef RTYPE_MEXT_EN
            10'b0000001_000: begin sp = longint'(sa) * longint'(sb); return {1'b0, sp[31:0]}; end
            10'b0000001_001: begin sp = longint'(sa) * longint'(sb); return {1'b0, sp[63:32]}; end
            10'b0000001_010: begin sp = longint'(sa) * longint'({32'b0, b}); return {1'b0, sp[63:32]}; end
            10'b0000001_011: begin up = {32'b0, a} * {32'b0, b}; return {1'b0, up[63:32]}; end
            10'b0000001_100: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb)};
            10'b0000001_101: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : 32'(a / b)};
            10'b0000001_110: return {1'b0, (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb)};
            10'b0000001_111: return {1'b0, (b == 0) ? a : 32'(a % b)};
`endif
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Scoreboard: record accepted ops, check delivered results and stall stability
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] m;
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_result", 64'(out_result), 64'(prev_res));
                check("stall_tag", 64'(out_tag), 64'(prev_tag));
                check("stall_illegal", 64'(out_illegal), 64'(prev_ill));
            end
            if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 64'(out_result), 64'(e.res));
                    check("sb_tag", 64'(out_tag), 64'(e.tag));
                    check("sb_illegal", 64'(out_illegal), 64'(e.ill));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
            prev_ill   = out_illegal;
            if (in_valid && in_ready) begin
                m = model(funct7, funct3, rs1, rs2);
                e.res = m[31:0];
                e.ill = m[32];
                e.tag = in_tag;
                exp_q.push_back(e);
            end
        end
    end

    // Present one op; returns just after the edge that accepted it
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] tg,
                         input logic [31:0] a, input logic [31:0] b);
        int w;
        funct7   = f7;
        funct3   = f3;
        in_tag   = tg;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        for (w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (w == 200) check("accept_timeout", 64'(1), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue one op with the consumer ready, then check latency and result against constants
    task automatic run_op(input string name, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [4:0] tg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ei, input int el);
        int n;
        issue(f7, f3, tg, a, b);
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_lat"}, 64'(n), 64'(el));
        check({name, "_res"}, 64'(out_result), 64'(er));
        check({name, "_tag"}, 64'(out_tag), 64'(tg));
        check({name, "_ill"}, 64'(out_illegal), 64'(ei));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [6:0] rand_f7();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 7'h00;
            5, 6:          return 7'h20;
            7, 8:          return 7'h01;
            default:       return 7'($urandom());
        endcase
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        prev_stall = 1'b0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        funct7     = '0;
        funct3     = '0;
        in_tag     = '0;
        rs1        = '0;
        rs2        = '0;
        hold_ready = 1'b1;
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_result", 64'(out_result), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_out_illegal", 64'(out_illegal), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Directed base ops and illegal encodings
        run_op("add_ovf", 7'h00, 3'b000, 5'd3, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        run_op("sra", 7'h20, 3'b101, 5'd4, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
        run_op("srl", 7'h00, 3'b101, 5'd5, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1);
        run_op("sltu", 7'h00, 3'b011, 5'd6, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1);
        run_op("slt", 7'h00, 3'b010, 5'd7, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        run_op("sub", 7'h20, 3'b000, 5'd8, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("ill_f7_20", 7'h20, 3'b100, 5'd9, 32'h1234, 32'h5678, 32'h0, 1'b1, 1);
`ifdef RTYPE_MEXT_EN
        run_op("mul", 7'h01, 3'b000, 5'd10, 32'h3, 32'h5, 32'hF, 1'b0, 1);
        run_op("mulhu", 7'h01, 3'b011, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("mulh", 7'h01, 3'b001, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        run_op("div", 7'h01, 3'b100, 5'd13, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem", 7'h01, 3'b110, 5'd14, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("divu_zero", 7'h01, 3'b101, 5'd15, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("div_ovf", 7'h01, 3'b100, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_op("rem_ovf", 7'h01, 3'b110, 5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
`else
        run_op("mul_ill", 7'h01, 3'b000, 5'd10, 32'h3, 32'h5, 32'h0, 1'b1, 1);
        run_op("div_ill", 7'h01, 3'b100, 5'd13, 32'hFFFF_FFF9, 32'h2, 32'h0, 1'b1, 1);
`endif

        // Output stall: one result held for 3 cycles while the next op waits
        hold_ready = 1'b0;
        issue(7'h00, 3'b000, 5'd20, 32'd10, 32'd20);
        funct7   = 7'h00;
        funct3   = 3'b100;
        in_tag   = 5'd21;
        rs1      = 32'hF0F0_F0F0;
        rs2      = 32'h0FF0_0FF0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold_ready", 64'(in_ready), 64'(0));
            check("stall_hold_res", 64'(out_result), 64'(30));
        end
        @(posedge clk);
        #1;
        hold_ready = 1'b1;
        issue(7'h00, 3'b100, 5'd21, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue(7'h00, 3'b110, 5'd22, 32'h1, 32'h2);
        issue(7'h00, 3'b001, 5'd23, 32'h1, 32'h1F);
        repeat (3) @(posedge clk);
        #1;
        check("stall_drain", 64'(exp_q.size()), 64'(0));

        // Reset asserted in the middle of a divide aborts it
        issue(7'h01, 3'b100, 5'd24, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
`ifdef RTYPE_MEXT_EN
        check("mid_div_busy", 64'(busy), 64'(1));
`else
        check("mid_div_busy", 64'(busy), 64'(0));
`endif
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op("add_after_rst", 7'h00, 3'b000, 5'd25, 32'd40, 32'd2, 32'd42, 1'b0, 1);

        // Randomized ops with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(rand_f7(), 3'($urandom()), 5'($urandom()), rand_operand(), rand_operand());
        end
        rand_ready = 1'b0;
        hold_ready = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("final_drain", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
